// File: rtl/pcie_link_status_mon.sv
// Link-status LEDs, debounced compliance push-button and link-state tracking for Arria V PCIe HIP test designs.
// Define LTSSM_HIST_EN to build the LTSSM change-history ring buffer behind hist_rd_idx/hist_rd_data.
module pcie_link_status_mon #(
  parameter int NUM_LANES  = 4,
  parameter int ALIVE_W    = 25,
  parameter int DBC_W      = 16,
  parameter int EVT_W      = 8,
  parameter int HIST_DEPTH = 8
) (
  input  logic                          pld_clk_clk,
  input  logic                          reset_reset,
  input  logic [4:0]                    ltssm,
  input  logic [3:0]                    neg_width,
  input  logic [1:0]                    cur_speed,
  input  logic                          req_compliance_pb,
  input  logic                          set_compliance_mode,
  output logic [NUM_LANES-1:0]          lane_active_led,
  output logic                          L0_led,
  output logic                          comp_led,
  output logic                          gen2_led,
  output logic                          alive_led,
  output logic                          comp_req,
  output logic                          link_up,
  output logic [EVT_W-1:0]              link_down_cnt,
  output logic [EVT_W-1:0]              recovery_cnt,
  output logic                          width_degraded,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
  output logic [4:0]                    hist_rd_data
);

  localparam logic [1:0] COMP_IDLE       = 2'd0;
  localparam logic [1:0] COMP_WAIT_ENTER = 2'd1;
  localparam logic [1:0] COMP_IN_COMP    = 2'd2;
  localparam logic [1:0] COMP_WAIT_EXIT  = 2'd3;

  localparam logic [1:0] LINK_DOWN  = 2'd0;
  localparam logic [1:0] LINK_TRAIN = 2'd1;
  localparam logic [1:0] LINK_UP    = 2'd2;
  localparam logic [1:0] LINK_RECOV = 2'd3;

  localparam logic [4:0] LTSSM_POLL_COMP = 5'h03;
  localparam logic [4:0] LTSSM_CFG_EXIT  = 5'h02;
  localparam logic [4:0] LTSSM_L0        = 5'h0F;

  localparam logic [EVT_W-1:0] EVT_MAX = '1;
  localparam logic [DBC_W-1:0] DBC_ONE = DBC_W'(1);

  logic [ALIVE_W-1:0]   r_heartbeat;
  logic [NUM_LANES-1:0] r_lane_led;
  logic                 r_l0_led;
  logic                 r_comp_led;
  logic                 r_gen2_led;
  logic [DBC_W-1:0]     r_dbc;
  logic                 r_press;
  logic [1:0]           r_comp_state;
  logic                 r_comp_req;
  logic [1:0]           r_link_state;
  logic [EVT_W-1:0]     r_link_down_cnt;
  logic [EVT_W-1:0]     r_recovery_cnt;
  logic                 r_width_degraded;

  logic [3:0]           w_width;
  logic [NUM_LANES-1:0] w_lane_next;
  logic                 w_narrow;
  logic                 w_ltssm_detect;
  logic                 w_ltssm_l0;
  logic                 w_ltssm_recov;

  // Numeric link width from the highest set bit of the one-hot width; 0 means no width reported.
  always_comb begin
    w_width = 4'd0;
    if (neg_width[3]) begin
      w_width = 4'd8;
    end else if (neg_width[2]) begin
      w_width = 4'd4;
    end else if (neg_width[1]) begin
      w_width = 4'd2;
    end else if (neg_width[0]) begin
      w_width = 4'd1;
    end
  end

  always_comb begin
    w_lane_next = r_lane_led;
    if (int'(w_width) > NUM_LANES) begin
      w_lane_next = {NUM_LANES{r_heartbeat[ALIVE_W-1]}};
    end else if (w_width != 4'd0) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        w_lane_next[i] = (i >= int'(w_width));
      end
    end
  end

  assign w_narrow       = (w_width != 4'd0) && (int'(w_width) < NUM_LANES);
  assign w_ltssm_detect = (ltssm <= 5'h01);
  assign w_ltssm_l0     = (ltssm == LTSSM_L0);
  assign w_ltssm_recov  = (ltssm >= 5'h0C) && (ltssm <= 5'h0E);

  always_ff @(posedge pld_clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_heartbeat <= '0;
      r_lane_led  <= '1;
      r_l0_led    <= 1'b1;
      r_comp_led  <= 1'b1;
      r_gen2_led  <= 1'b1;
    end else begin
      r_heartbeat <= r_heartbeat + ALIVE_W'(1);
      r_lane_led  <= w_lane_next;
      r_l0_led    <= ~(ltssm == LTSSM_L0);
      r_comp_led  <= ~(ltssm == LTSSM_POLL_COMP);
      r_gen2_led  <= ~(cur_speed == 2'b10);
    end
  end

  // Press event fires on the single cycle the counter steps from 1 to 0 with the button still released.
  always_ff @(posedge pld_clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_dbc   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= req_compliance_pb && (r_dbc == DBC_ONE);
      if (!req_compliance_pb) begin
        r_dbc <= '1;
      end else if (r_dbc != '0) begin
        r_dbc <= r_dbc - DBC_W'(1);
      end
    end
  end

  always_ff @(posedge pld_clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_comp_state <= COMP_IDLE;
      r_comp_req   <= 1'b0;
    end else begin
      r_comp_req <= 1'b0;
      if (!set_compliance_mode) begin
        r_comp_state <= COMP_IDLE;
      end else begin
        case (r_comp_state)
          COMP_IDLE: begin
            if (r_press) begin
              r_comp_req   <= 1'b1;
              r_comp_state <= COMP_WAIT_ENTER;
            end
          end
          COMP_WAIT_ENTER: begin
            if (ltssm == LTSSM_POLL_COMP) begin
              r_comp_state <= COMP_IN_COMP;
            end
          end
          COMP_IN_COMP: begin
            if (r_press) begin
              r_comp_req   <= 1'b1;
              r_comp_state <= COMP_WAIT_EXIT;
            end
          end
          COMP_WAIT_EXIT: begin
            if (ltssm == LTSSM_CFG_EXIT) begin
              r_comp_state <= COMP_IDLE;
            end
          end
          default: r_comp_state <= COMP_IDLE;
        endcase
      end
    end
  end

  // Degradation is judged only on cycles that enter UP, from either TRAIN or RECOV.
  always_ff @(posedge pld_clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_link_state     <= LINK_DOWN;
      r_link_down_cnt  <= '0;
      r_recovery_cnt   <= '0;
      r_width_degraded <= 1'b0;
    end else begin
      case (r_link_state)
        LINK_DOWN: begin
          if (!w_ltssm_detect) begin
            r_link_state <= LINK_TRAIN;
          end
        end
        LINK_TRAIN: begin
          if (w_ltssm_l0) begin
            r_link_state <= LINK_UP;
            if (w_narrow) begin
              r_width_degraded <= 1'b1;
            end
          end else if (w_ltssm_detect) begin
            r_link_state <= LINK_DOWN;
          end
        end
        LINK_UP: begin
          if (w_ltssm_recov) begin
            r_link_state <= LINK_RECOV;
            if (r_recovery_cnt != EVT_MAX) begin
              r_recovery_cnt <= r_recovery_cnt + EVT_W'(1);
            end
          end else if (w_ltssm_detect) begin
            r_link_state <= LINK_DOWN;
            if (r_link_down_cnt != EVT_MAX) begin
              r_link_down_cnt <= r_link_down_cnt + EVT_W'(1);
            end
          end
        end
        LINK_RECOV: begin
          if (w_ltssm_l0) begin
            r_link_state <= LINK_UP;
            if (w_narrow) begin
              r_width_degraded <= 1'b1;
            end
          end else if (w_ltssm_detect) begin
            r_link_state <= LINK_DOWN;
            if (r_link_down_cnt != EVT_MAX) begin
              r_link_down_cnt <= r_link_down_cnt + EVT_W'(1);
            end
          end
        end
        default: r_link_state <= LINK_DOWN;
      endcase
    end
  end

`ifdef LTSSM_HIST_EN
  localparam int IDX_W = $clog2(HIST_DEPTH);

  logic [4:0]       r_hist [HIST_DEPTH];
  logic [IDX_W-1:0] r_wptr;
  logic [4:0]       r_prev_ltssm;
  logic [4:0]       r_hist_rd_data;
  logic [IDX_W-1:0] w_rd_ptr;

  // Index 0 is the newest entry, i.e. the slot just behind the write pointer.
  assign w_rd_ptr = r_wptr - IDX_W'(1) - hist_rd_idx;

  always_ff @(posedge pld_clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        r_hist[i] <= 5'h00;
      end
      r_wptr         <= '0;
      r_prev_ltssm   <= 5'h00;
      r_hist_rd_data <= 5'h00;
    end else begin
      r_prev_ltssm   <= ltssm;
      r_hist_rd_data <= r_hist[w_rd_ptr];
      if (ltssm != r_prev_ltssm) begin
        r_hist[r_wptr] <= ltssm;
        r_wptr         <= r_wptr + IDX_W'(1);
      end
    end
  end

  assign hist_rd_data = r_hist_rd_data;
`else
  logic w_unused_hist_idx;

  assign w_unused_hist_idx = ^hist_rd_idx;
  assign hist_rd_data      = 5'h00;
`endif

  assign lane_active_led = r_lane_led;
  assign L0_led          = r_l0_led;
  assign comp_led        = r_comp_led;
  assign gen2_led        = r_gen2_led;
  assign alive_led       = r_heartbeat[ALIVE_W-1];
  assign comp_req        = r_comp_req;
  assign link_up         = (r_link_state == LINK_UP);
  assign link_down_cnt   = r_link_down_cnt;
  assign recovery_cnt    = r_recovery_cnt;
  assign width_degraded  = r_width_degraded;

endmodule

// File: doc/pcie_link_status_mon.md
Name: pcie_link_status_mon

Overview:
- Parametrised link-status and compliance-control block for Arria V PCIe hard-IP test designs. Replaces per-design LED/compliance glue in the top-level with one reusable block.
- Sits beside the HIP instance on the pld clock. Consumes the LTSSM state, negotiated width/speed and the compliance push-button.
- Produces active-low LEDs, a debounced compliance request, link-state tracking and saturating event counters.

Parameters:
- NUM_LANES, 4, supported lane count (1, 2, 4 or 8); width of lane LED bus.
- ALIVE_W, 25, heartbeat counter width; MSB drives alive_led and blink.
- DBC_W, 16, push-button debounce counter width.
- EVT_W, 8, width of each saturating event counter.
- HIST_DEPTH, 8, LTSSM history depth (power of 2); used only with the optional feature.

Ports:
- pld_clk_clk  in  1  sole clock; all logic is synchronous to it.
- reset_reset  in  1  asynchronous, active-high reset.
- ltssm  in  5  HIP LTSSM state.
- neg_width  in  4  one-hot negotiated width {x8,x4,x2,x1}.
- cur_speed  in  2  current link speed; 2'b10 = Gen2.
- req_compliance_pb  in  1  raw push-button, active-low.
- set_compliance_mode  in  1  static strap; 1 = compliance mode enabled.
- lane_active_led  out  NUM_LANES  active-low; one LED per active lane.
- L0_led  out  1  active-low; lit while in L0.
- comp_led  out  1  active-low; lit while in Poll.Compliance.
- gen2_led  out  1  active-low; lit at Gen2 speed.
- alive_led  out  1  heartbeat.
- comp_req  out  1  one-cycle pulse requesting compliance entry/exit.
- link_up  out  1  link-state machine is in UP.
- link_down_cnt  out  EVT_W  count of UP to DOWN transitions.
- recovery_cnt  out  EVT_W  count of UP to RECOV transitions.
- width_degraded  out  1  sticky; negotiated width is narrower than NUM_LANES.
- hist_rd_idx  in  log2(HIST_DEPTH)  history read index (0 = newest).
- hist_rd_data  out  5  LTSSM history entry.

Behaviour:
- Reset values:
  - All LEDs 1 (off). lane_active_led all 1.
  - alive_led 0, comp_req 0, link_up 0, width_degraded 0.
  - Counters 0, heartbeat 0, hist_rd_data 0.
  - Both FSMs in their first-listed state.
- LED registers:
  - All LED outputs are registered; 1-cycle latency from inputs.
  - L0_led = ~(ltssm==5'h0F).
  - comp_led = ~(ltssm==5'h03).
  - gen2_led = ~(cur_speed==2'b10).
  - alive_led = heartbeat MSB; heartbeat is free-running and wraps.
- Lane LEDs:
  - The highest set bit of neg_width gives width W.
  - The low min(W, NUM_LANES) LEDs are driven 0; the rest are driven 1.
  - If W > NUM_LANES: all lanes blink at the heartbeat MSB (illegal width).
  - If neg_width == 0: hold the previous value.
- Debounce:
  - Counter loads all-ones while the button is 0 and decrements to 0 while it is 1.
  - A registered press event fires exactly once, when the counter reaches 1.
  - A bounce restarts the count.
- Compliance FSM (states IDLE, WAIT_ENTER, IN_COMP, WAIT_EXIT):
  - IDLE: on press event with set_compliance_mode=1, pulse comp_req and go to WAIT_ENTER.
  - WAIT_ENTER: when ltssm==5'h03, go to IN_COMP.
  - IN_COMP: on press event, pulse comp_req and go to WAIT_EXIT.
  - WAIT_EXIT: when ltssm==5'h02, go to IDLE.
  - Press events in WAIT_* states are ignored.
  - set_compliance_mode falling to 0 forces IDLE next cycle, with no pulse.
- Link FSM (states DOWN, TRAIN, UP, RECOV):
  - DOWN to TRAIN when ltssm is not in 0..1.
  - TRAIN to UP on ltssm==5'h0F.
  - UP to RECOV on ltssm in 5'h0C..5'h0E; recovery_cnt increments.
  - RECOV to UP on 5'h0F.
  - UP or RECOV to DOWN on ltssm in 0..1; link_down_cnt increments only if the state was UP or RECOV.
  - TRAIN to DOWN on ltssm in 0..1, with no count.
  - link_up = (state==UP).
- Counters saturate at all-ones and never wrap.
- width_degraded sets on the first UP-entry cycle where W < NUM_LANES. It is cleared only by reset.
- Reset mid-operation: all state returns to reset values asynchronously. Release is synchronous to the clock.

Optional Feature:
- LTSSM_HIST_EN defined:
  - A HIST_DEPTH ring buffer records ltssm on every cycle where it differs from the previous cycle's value.
  - The write pointer wraps; the oldest entry is overwritten.
  - hist_rd_data is registered: entry (wptr-1-hist_rd_idx), 1-cycle latency.
  - Entries never written read 5'h00.
- LTSSM_HIST_EN undefined: no buffer is built; hist_rd_data is tied to 0 and hist_rd_idx is ignored.

Test Plan:
- Reset, then ltssm 0 to 2 to 0x0F, neg_width=4'b0100, cur_speed=2'b10 -> one cycle later: L0_led=0, gen2_led=0, lane_active_led=4'b0000, link_up=1, width_degraded=0.
- NUM_LANES=4, neg_width=4'b1000 -> lane_active_led toggles between 4'b0000 and 4'b1111 with the heartbeat MSB; neg_width=4'b0001 on UP entry -> lane_active_led=4'b1110 and width_degraded stays 1.
- Button low for 10 cycles then high, set_compliance_mode=1 (DBC_W=4 override) -> exactly one comp_req pulse 16 cycles after release. A second press before ltssm=3 gives no pulse. Press after ltssm=3 gives a pulse; ltssm=2 then returns the FSM to IDLE.
- Link up, then 0x0C, 0x0F, 0x0C, 0x00 -> recovery_cnt=2, link_down_cnt=1. EVT_W=2 with 5 link drops -> link_down_cnt=3 (saturated).
- With LTSSM_HIST_EN, HIST_DEPTH=8: drive 10 distinct ltssm changes -> idx 0 returns the last value, idx 7 returns the 3rd value. Without the macro -> hist_rd_data=0.
- Assert reset_reset mid-IN_COMP with link_up=1 -> all outputs return to reset values immediately. After release, the FSMs restart from IDLE and DOWN.
